// File: rtl/ram_param_pkg.sv
// Shared definitions for the Thistle parametrised RAM: FSM states and default widths.
package ram_param_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PROG  = 2'd2
  } ram_state_e;

endpackage

// File: rtl/ram_param_if.sv
// Bus-side and loader-side control signals of the Thistle RAM.
interface ram_param_if
  import ram_param_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] mar_in;
  logic              mar_wr;
  logic              mar_inc;
  logic              we;
  logic              oe;
  logic              program_mode;
  logic              pm_addr_ld;
  logic [ADDR_W-1:0] pm_addr;
  logic              pm_valid;
  logic [DATA_W-1:0] pm_data;
  logic              pm_ready;
  logic              busy;
  logic [ADDR_W-1:0] mar_out;

  modport master (
    output mar_in, mar_wr, mar_inc, we, oe, program_mode,
    output pm_addr_ld, pm_addr, pm_valid, pm_data,
    input  pm_ready, busy, mar_out
  );

  modport slave (
    input  mar_in, mar_wr, mar_inc, we, oe, program_mode,
    input  pm_addr_ld, pm_addr, pm_valid, pm_data,
    output pm_ready, busy, mar_out
  );

endinterface

// File: rtl/ram_param_core.sv
// Synchronous single-port array with registered read; no reset so it maps onto block RAM.
module ram_param_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port plus read-before-write registered read of the same address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/ram_param.sv
// Thistle RAM top: clear engine, MAR, program-mode loader and tri-state bus driver.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] data,
  ram_param_if.slave        bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam ram_state_e        ST_RST   = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] hold_q;
  logic              busy_q;
  logic              pm_ready_q;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_out_c;
  logic              bus_drv_c;

  // Next state, MAR update and write-port mux between clear engine, loader and bus.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    clear_ptr_d = clear_ptr_q;
    rd_pend_d   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = mar_q;
    mem_wdata_c = '0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = clear_ptr_q;
        clear_ptr_d = clear_ptr_q + ADDR_W'(1);
        if (clear_ptr_q == ADDR_MAX) begin
          state_d = bus.program_mode ? ST_PROG : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.program_mode) begin
          state_d = ST_PROG;
        end else begin
          if (bus.mar_wr) begin
            mar_d = bus.mar_in;
          end else if (bus.mar_inc) begin
            mar_d = mar_q + ADDR_W'(1);
          end
          // Access uses the pre-update MAR; write beats read.
          if (bus.we) begin
            mem_we_c    = 1'b1;
            mem_wdata_c = data;
          end else if (bus.oe) begin
            rd_pend_d = 1'b1;
          end
        end
      end
      ST_PROG: begin
        if (!bus.program_mode) begin
          state_d = ST_RUN;
        end
        if (bus.pm_valid && pm_ready_q) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = bus.pm_data;
          if (bus.pm_addr_ld) begin
            mem_addr_c = bus.pm_addr;
            mar_d      = bus.pm_addr + ADDR_W'(1);
          end else begin
            mar_d = mar_q + ADDR_W'(1);
          end
        end else if (bus.pm_addr_ld) begin
          mar_d = bus.pm_addr;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, MAR, clear pointer and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RST;
      mar_q       <= '0;
      clear_ptr_q <= '0;
      rd_pend_q   <= 1'b0;
      hold_q      <= '0;
      busy_q      <= CLEAR_ON_RST;
      pm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      clear_ptr_q <= clear_ptr_d;
      rd_pend_q   <= rd_pend_d;
      hold_q      <= data_out_c;
      busy_q      <= (state_d == ST_CLEAR);
      pm_ready_q  <= (state_d == ST_PROG);
    end
  end

  ram_param_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .wr_en (mem_we_c),
    .addr  (mem_addr_c),
    .wdata (mem_wdata_c),
    .rdata (mem_rdata)
  );

  // data_out: fresh array word after a read, otherwise the last value held.
  assign data_out_c = rd_pend_q ? mem_rdata : hold_q;
  assign bus_drv_c  = (state_q == ST_RUN) && bus.oe && !bus.we;
  assign data       = bus_drv_c ? data_out_c : {DATA_W{1'bz}};

  assign bus.pm_ready = pm_ready_q;
  assign bus.busy     = busy_q;
  assign bus.mar_out  = mar_q;

endmodule

// File: tb/tb_ram_param.sv
// Directed self-checking bench for ram_param (DATA_W=8, ADDR_W=8, CLEAR_ON_RST=1).
module tb_ram_param;

  logic clk = 1'b0;
  logic rst;
  logic       tb_drv_en;
  logic [7:0] tb_drv;
  tri1  [7:0] data_bus;

  int vecs = 0;
  int errs = 0;

  ram_param_if #(.DATA_W(8), .ADDR_W(8)) bus_if ();

  ram_param #(
    .DATA_W       (8),
    .ADDR_W       (8),
    .CLEAR_ON_RST (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data_bus),
    .bus  (bus_if)
  );

  assign data_bus = tb_drv_en ? tb_drv : 8'bz;

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus_if.mar_in       = 8'h00;
    bus_if.mar_wr       = 1'b0;
    bus_if.mar_inc      = 1'b0;
    bus_if.we           = 1'b0;
    bus_if.oe           = 1'b0;
    bus_if.program_mode = 1'b0;
    bus_if.pm_addr_ld   = 1'b0;
    bus_if.pm_addr      = 8'h00;
    bus_if.pm_valid     = 1'b0;
    bus_if.pm_data      = 8'h00;
    tb_drv_en           = 1'b0;
    tb_drv              = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_clear(output int cyc);
    cyc = 0;
    while (bus_if.busy === 1'b1 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic rd_word(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    bus_if.mar_wr = 1'b1;
    bus_if.mar_in = a;
    @(negedge clk);
    bus_if.mar_wr = 1'b0;
    bus_if.oe     = 1'b1;
    @(posedge clk);
    #1;
    v = data_bus;
    @(negedge clk);
    bus_if.oe = 1'b0;
  endtask

  task automatic wr_word(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.mar_wr = 1'b1;
    bus_if.mar_in = a;
    @(negedge clk);
    bus_if.mar_wr = 1'b0;
    bus_if.we     = 1'b1;
    tb_drv        = d;
    tb_drv_en     = 1'b1;
    @(negedge clk);
    bus_if.we = 1'b0;
    tb_drv_en = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    logic [7:0] v;
    logic [7:0] addrs [3];
    addrs = '{8'h00, 8'h7F, 8'hFF};
    rst = 1'b0;
    idle_inputs();
    bus_if.oe = 1'b1;
    #12;
    vecs++;
    if (bus_if.busy !== 1'b1 || bus_if.pm_ready !== 1'b0 || bus_if.mar_out !== 8'h00) begin
      errs++;
      $display("FAIL reset_state: busy=%b pm_ready=%b mar_out=%h, required 1 0 00",
               bus_if.busy, bus_if.pm_ready, bus_if.mar_out);
    end
    vecs++;
    if (data_bus !== 8'hFF) begin
      errs++;
      $display("FAIL reset_bus_released: bus=%h, required FF (released)", data_bus);
    end
    @(negedge clk);
    bus_if.oe = 1'b0;
    rst = 1'b1;
    wait_clear(cyc);
    vecs++;
    if (cyc != 256) begin
      errs++;
      $display("FAIL clear_length: busy cycles=%0d, required 256", cyc);
    end
    foreach (addrs[i]) begin
      rd_word(addrs[i], v);
      vecs++;
      if (v !== 8'h00) begin
        errs++;
        $display("FAIL clear_read[%h]: got %h, required 00", addrs[i], v);
      end
    end
  endtask

  task automatic test_prog();
    logic [7:0] v;
    logic [7:0] addrs [4];
    logic [7:0] exp   [4];
    addrs = '{8'hFE, 8'hFF, 8'h00, 8'h30};
    exp   = '{8'hA1, 8'hB2, 8'hC3, 8'h77};
    @(negedge clk);
    bus_if.program_mode = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (bus_if.pm_ready !== 1'b1) begin
      errs++;
      $display("FAIL prog_ready: pm_ready=%b, required 1", bus_if.pm_ready);
    end
    @(negedge clk);
    bus_if.pm_addr_ld = 1'b1;
    bus_if.pm_addr    = 8'hFE;
    bus_if.oe         = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (bus_if.mar_out !== 8'hFE || data_bus !== 8'hFF) begin
      errs++;
      $display("FAIL prog_addr_ld: mar_out=%h bus=%h, required FE FF", bus_if.mar_out, data_bus);
    end
    @(negedge clk);
    bus_if.pm_addr_ld = 1'b0;
    bus_if.oe         = 1'b0;
    bus_if.pm_valid   = 1'b1;
    bus_if.pm_data    = 8'hA1;
    @(negedge clk);
    bus_if.pm_data = 8'hB2;
    @(negedge clk);
    bus_if.pm_data = 8'hC3;
    @(negedge clk);
    bus_if.pm_valid = 1'b0;
    vecs++;
    if (bus_if.mar_out !== 8'h01) begin
      errs++;
      $display("FAIL prog_mar_wrap: mar_out=%h, required 01", bus_if.mar_out);
    end
    bus_if.pm_addr_ld = 1'b1;
    bus_if.pm_addr    = 8'h30;
    bus_if.pm_valid   = 1'b1;
    bus_if.pm_data    = 8'h77;
    @(negedge clk);
    bus_if.pm_addr_ld = 1'b0;
    bus_if.pm_valid   = 1'b0;
    vecs++;
    if (bus_if.mar_out !== 8'h31) begin
      errs++;
      $display("FAIL prog_ld_and_xfer: mar_out=%h, required 31", bus_if.mar_out);
    end
    bus_if.program_mode = 1'b0;
    @(posedge clk);
    #1;
    vecs++;
    if (bus_if.pm_ready !== 1'b0 || bus_if.mar_out !== 8'h31) begin
      errs++;
      $display("FAIL prog_exit: pm_ready=%b mar_out=%h, required 0 31",
               bus_if.pm_ready, bus_if.mar_out);
    end
    foreach (addrs[i]) begin
      rd_word(addrs[i], v);
      vecs++;
      if (v !== exp[i]) begin
        errs++;
        $display("FAIL prog_readback[%h]: got %h, required %h", addrs[i], v, exp[i]);
      end
    end
  endtask

  task automatic test_run_rw();
    wr_word(8'h10, 8'h5A);
    @(negedge clk);
    bus_if.mar_wr = 1'b1;
    bus_if.mar_in = 8'h10;
    #1;
    vecs++;
    if (data_bus !== 8'hFF) begin
      errs++;
      $display("FAIL run_bus_idle: bus=%h, required FF (released)", data_bus);
    end
    @(negedge clk);
    bus_if.mar_wr = 1'b0;
    bus_if.oe     = 1'b1;
    @(posedge clk);
    #1;
    vecs++;
    if (data_bus !== 8'h5A) begin
      errs++;
      $display("FAIL run_read_2nd_oe: bus=%h, required 5A", data_bus);
    end
    @(negedge clk);
    bus_if.oe     = 1'b0;
    bus_if.mar_wr = 1'b1;
    bus_if.mar_in = 8'h11;
    @(negedge clk);
    bus_if.mar_wr = 1'b0;
    bus_if.we     = 1'b1;
    bus_if.oe     = 1'b1;
    #1;
    vecs++;
    if (data_bus !== 8'hFF) begin
      errs++;
      $display("FAIL run_we_oe_bus: bus=%h, required FF (released)", data_bus);
    end
    @(negedge clk);
    bus_if.we = 1'b0;
    #1;
    vecs++;
    if (data_bus !== 8'h5A) begin
      errs++;
      $display("FAIL run_we_oe_hold: bus=%h, required 5A", data_bus);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (data_bus !== 8'hFF) begin
      errs++;
      $display("FAIL run_we_oe_write: bus=%h, required FF", data_bus);
    end
    @(negedge clk);
    bus_if.oe = 1'b0;
  endtask

  task automatic test_inc_we();
    logic [7:0] v;
    @(negedge clk);
    bus_if.mar_wr = 1'b1;
    bus_if.mar_in = 8'h20;
    @(negedge clk);
    bus_if.mar_wr  = 1'b0;
    bus_if.mar_inc = 1'b1;
    bus_if.we      = 1'b1;
    tb_drv         = 8'h33;
    tb_drv_en      = 1'b1;
    @(negedge clk);
    bus_if.mar_inc = 1'b0;
    bus_if.we      = 1'b0;
    tb_drv_en      = 1'b0;
    vecs++;
    if (bus_if.mar_out !== 8'h21) begin
      errs++;
      $display("FAIL inc_we_mar: mar_out=%h, required 21", bus_if.mar_out);
    end
    rd_word(8'h20, v);
    vecs++;
    if (v !== 8'h33) begin
      errs++;
      $display("FAIL inc_we_data: mem[20]=%h, required 33", v);
    end
    rd_word(8'h21, v);
    vecs++;
    if (v !== 8'h00) begin
      errs++;
      $display("FAIL inc_we_post_addr: mem[21]=%h, required 00", v);
    end
    @(negedge clk);
    bus_if.mar_wr  = 1'b1;
    bus_if.mar_inc = 1'b1;
    bus_if.mar_in  = 8'h40;
    @(negedge clk);
    bus_if.mar_wr  = 1'b0;
    bus_if.mar_inc = 1'b0;
    vecs++;
    if (bus_if.mar_out !== 8'h40) begin
      errs++;
      $display("FAIL mar_wr_priority: mar_out=%h, required 40", bus_if.mar_out);
    end
    bus_if.mar_wr = 1'b1;
    bus_if.mar_in = 8'hFF;
    @(negedge clk);
    bus_if.mar_wr  = 1'b0;
    bus_if.mar_inc = 1'b1;
    @(negedge clk);
    bus_if.mar_inc = 1'b0;
    vecs++;
    if (bus_if.mar_out !== 8'h00) begin
      errs++;
      $display("FAIL mar_inc_wrap: mar_out=%h, required 00", bus_if.mar_out);
    end
  endtask

  task automatic test_prog_during_clear();
    int cyc;
    int bad;
    logic [7:0] v;
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    bus_if.program_mode = 1'b1;
    bus_if.pm_valid     = 1'b1;
    bus_if.pm_data      = 8'hEE;
    cyc = 100;
    bad = 0;
    while (bus_if.busy === 1'b1 && cyc < 1000) begin
      if (bus_if.pm_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    vecs++;
    if (cyc != 256 || bad != 0) begin
      errs++;
      $display("FAIL pm_clear_busy: busy cycles=%0d early pm_ready=%0d, required 256 0", cyc, bad);
    end
    vecs++;
    if (bus_if.pm_ready !== 1'b1) begin
      errs++;
      $display("FAIL pm_clear_ready: pm_ready=%b, required 1", bus_if.pm_ready);
    end
    bus_if.pm_valid = 1'b0;
    @(negedge clk);
    bus_if.program_mode = 1'b0;
    @(posedge clk);
    #1;
    vecs++;
    if (bus_if.pm_ready !== 1'b0) begin
      errs++;
      $display("FAIL pm_clear_exit: pm_ready=%b, required 0", bus_if.pm_ready);
    end
    rd_word(8'h00, v);
    vecs++;
    if (v !== 8'h00) begin
      errs++;
      $display("FAIL pm_clear_nowrite[00]: got %h, required 00", v);
    end
    rd_word(8'h64, v);
    vecs++;
    if (v !== 8'h00) begin
      errs++;
      $display("FAIL pm_clear_nowrite[64]: got %h, required 00", v);
    end
  endtask

  task automatic test_reset_mid_load();
    int cyc;
    logic [7:0] v;
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    @(negedge clk);
    bus_if.program_mode = 1'b1;
    @(negedge clk);
    bus_if.pm_addr_ld = 1'b1;
    bus_if.pm_addr    = 8'h80;
    @(negedge clk);
    bus_if.pm_addr_ld = 1'b0;
    bus_if.pm_valid   = 1'b1;
    foreach (words[i]) begin
      bus_if.pm_data = words[i];
      if (i < 3) @(negedge clk);
    end
    @(posedge clk);
    #2;
    bus_if.oe = 1'b1;
    rst = 1'b0;
    #1;
    vecs++;
    if (bus_if.pm_ready !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.mar_out !== 8'h00) begin
      errs++;
      $display("FAIL midload_reset: pm_ready=%b busy=%b mar_out=%h, required 0 1 00",
               bus_if.pm_ready, bus_if.busy, bus_if.mar_out);
    end
    vecs++;
    if (data_bus !== 8'hFF) begin
      errs++;
      $display("FAIL midload_bus: bus=%h, required FF (released)", data_bus);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_clear(cyc);
    vecs++;
    if (cyc != 256) begin
      errs++;
      $display("FAIL midload_clear_length: busy cycles=%0d, required 256", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      rd_word(8'h80 + 8'(i), v);
      vecs++;
      if (v !== 8'h00) begin
        errs++;
        $display("FAIL midload_cleared[%0d]: got %h, required 00", i, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prog();
    test_run_rw();
    test_inc_we();
    test_prog_during_clear();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
